uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, meaning the number of byte-stream requesters sharing one UART TX FIFO write port (2..8).
REQ-002 The block SHALL have parameter TimeoutBits, default 16, meaning the width of the mid-packet stall timeout.
REQ-003 The block SHALL have port i_clk  input  1  single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port c_timeout  input  TimeoutBits  stall limit in cycles; 0 disables the timeout.
REQ-006 The block SHALL have port i_req_valid  input  NumReq  per-requester byte valid.
REQ-007 The block SHALL have port i_req_last  input  NumReq  per-requester last-byte-of-packet flag, qualified by valid.
REQ-008 The block SHALL have port i_req_data  input  NumReq*8  per-requester byte; requester n uses bits [8n+7:8n].
REQ-009 The block SHALL have port o_req_ready  output  NumReq  per-requester byte accepted this cycle when valid is also high.
REQ-010 The block SHALL have port i_fifo_full  input  1  UART TX FIFO full.
REQ-011 The block SHALL have port o_fifo_write  output  1  UART TX FIFO write strobe.
REQ-012 The block SHALL have port o_fifo_wdata  output  8  UART TX FIFO write data.
REQ-013 The block SHALL have port o_busy  output  1  high while a packet owns the TX port.
REQ-014 The block SHALL have port o_grant_id  output  $clog2(NumReq)  index of the current owner; holds the last owner when idle.
REQ-015 The block SHALL have port o_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-016 The FSM SHALL have two states: IDLE and GRANT.
REQ-017 In IDLE with any i_req_valid high, the block SHALL select the first valid requester searching upward from (rr_ptr), wrapping modulo NumReq, latch it into o_grant_id and enter GRANT on the next edge.
REQ-018 In IDLE, o_req_ready SHALL be all zero and o_fifo_write SHALL be 0; the earliest byte acceptance is the cycle after valid is first sampled in IDLE.
REQ-019 In GRANT, o_req_ready[o_grant_id] SHALL equal ~i_fifo_full (combinational), and all other ready bits SHALL be 0.
REQ-020 o_fifo_write SHALL equal i_req_valid[o_grant_id] & o_req_ready[o_grant_id]; o_fifo_wdata SHALL be the granted requester's byte (combinational, zero added latency).
REQ-021 Never more than one byte SHALL be written per cycle, and no byte SHALL be written while i_fifo_full is high.
REQ-022 A transfer with i_req_last high SHALL return the FSM to IDLE on the next edge and set rr_ptr to (o_grant_id+1) mod NumReq.
REQ-023 Grant SHALL be held for the whole packet: valid/last from other requesters SHALL be ignored in GRANT.
REQ-024 A stall counter SHALL clear on every transfer and on GRANT entry, and increment each GRANT cycle where i_req_valid[o_grant_id] is low; cycles stalled only by i_fifo_full SHALL NOT count.
REQ-025 When c_timeout != 0 and the stall counter reaches c_timeout, the block SHALL pulse o_timeout for one cycle, go to IDLE, and advance rr_ptr as in REQ-022.
REQ-026 The stall counter SHALL saturate at all ones and never wrap.
REQ-027 A requester asserting valid on the timeout cycle SHALL not be accepted on that cycle.
REQ-028 c_timeout changes SHALL take effect on the next cycle; the block SHALL be used with c_timeout static while o_busy is high.
REQ-029 o_busy SHALL be high exactly when state is GRANT.

Reset
REQ-030 While i_rst is high on a clock edge, state SHALL become IDLE, rr_ptr 0, o_grant_id 0, stall counter 0, o_timeout 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no further fifo writes from the cycle after the reset edge; o_req_ready and o_fifo_write SHALL be 0 while in reset.

Verification
REQ-032 Single requester: req1 sends 0x41,0x42(last), fifo never full -> fifo writes 0x41,0x42 on consecutive cycles starting one cycle after first valid, o_grant_id=1, o_busy drops after last.
REQ-033 Round robin: req0 and req2 continuously send 2-byte packets -> packet order 0,2,0,2; no byte interleaving between packets.
REQ-034 Backpressure: i_fifo_full high 5 cycles mid-packet, c_timeout=3 -> no writes, no o_timeout, packet resumes intact.
REQ-035 Timeout: c_timeout=4, granted req3 drops valid after byte 1 -> o_timeout pulses on 4th stall cycle, next pending requester granted, rr_ptr=0.
REQ-036 Reset mid-packet: i_rst high during byte 2 of 4 -> o_fifo_write 0 from next cycle, after release req0 has priority over req1 with both valid.
REQ-037 Timeout disabled: c_timeout=0, granted requester idles 70000 cycles -> grant held, counter saturated, no o_timeout.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter giving NumReq byte streams packet-atomic
// access to one UART TX FIFO write port, with a mid-packet stall timeout.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   c_timeout               stall limit in cycles, 0 disables the timeout
//   i_req_valid/last/data   per-requester byte stream (byte n at [8n+7:8n])
//   o_req_ready             per-requester accept, only the owner may be high
//   i_fifo_full             TX FIFO full
//   o_fifo_write/wdata      TX FIFO write strobe and byte
//   o_busy                  a packet owns the port
//   o_grant_id              current owner, holds the last owner when idle
//   o_timeout               one-cycle pulse when a grant is revoked by timeout
module uart_tx_arb #(
  parameter int NumReq      = 4,
  parameter int TimeoutBits = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [TimeoutBits-1:0]     c_timeout,
  input  logic [NumReq-1:0]          i_req_valid,
  input  logic [NumReq-1:0]          i_req_last,
  input  logic [NumReq*8-1:0]        i_req_data,
  output logic [NumReq-1:0]          o_req_ready,
  input  logic                       i_fifo_full,
  output logic                       o_fifo_write,
  output logic [7:0]                 o_fifo_wdata,
  output logic                       o_busy,
  output logic [$clog2(NumReq)-1:0]  o_grant_id,
  output logic                       o_timeout
);

  localparam int IdW = $clog2(NumReq);
  localparam logic [TimeoutBits-1:0] CntMax = '1;
  localparam logic [TimeoutBits-1:0] CntOne = TimeoutBits'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                 state;
  logic [IdW-1:0]         rr_ptr;
  logic [TimeoutBits-1:0] stall_cnt;
  logic [TimeoutBits-1:0] stall_inc;
  logic                   cur_valid;
  logic                   cur_last;
  logic                   grant_ok;
  logic                   xfer;
  logic                   expire;
  logic                   pick_found;
  logic [IdW-1:0]         pick_id;
  logic [IdW-1:0]         next_ptr;

  // Index arithmetic modulo NumReq, which need not be a power of two.
  function automatic logic [IdW-1:0] wrap_add(
    input logic [IdW-1:0] base,
    input int             ofs
  );
    int s;
    s = int'(base) + ofs;
    if (s >= NumReq) s = s - NumReq;
    return IdW'(s);
  endfunction

  always_comb begin
    cur_valid = i_req_valid[o_grant_id];
    cur_last  = i_req_last[o_grant_id];
    grant_ok  = (state == GRANT) && !i_fifo_full && !i_rst;
    xfer      = grant_ok && cur_valid;

    o_req_ready = '0;
    if (grant_ok) o_req_ready[o_grant_id] = 1'b1;

    o_fifo_write = xfer;
    o_fifo_wdata = i_req_data[int'(o_grant_id)*8 +: 8];
    o_busy       = (state == GRANT);

    // Saturating increment so a long idle owner never wraps into a timeout.
    stall_inc = (stall_cnt == CntMax) ? stall_cnt : stall_cnt + CntOne;
    expire    = (c_timeout != '0) && (stall_inc >= c_timeout);
    next_ptr  = wrap_add(o_grant_id, 1);
  end

  // Scan downward so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (i_req_valid[wrap_add(rr_ptr, i)]) begin
        pick_found = 1'b1;
        pick_id    = wrap_add(rr_ptr, i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      o_grant_id <= '0;
      stall_cnt  <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            o_grant_id <= pick_id;
            stall_cnt  <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (cur_last) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end else if (!cur_valid) begin
            // FIFO-full cycles with valid high are not owner stalls.
            stall_cnt <= stall_inc;
            if (expire) begin
              o_timeout <= 1'b1;
              state     <= IDLE;
              rr_ptr    <= next_ptr;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: packet table plus hand sequences for round robin,
// backpressure, timeout, mid-packet reset and disabled timeout.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int TB = 10;
  localparam int D  = 64;

  logic          clk;
  logic          rst;
  logic [TB-1:0] c_timeout;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_write;
  logic [7:0]    fifo_wdata;
  logic          busy;
  logic [1:0]    grant_id;
  logic          timeout;

  uart_tx_arb #(.NumReq(N), .TimeoutBits(TB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .c_timeout    (c_timeout),
    .i_req_valid  (req_valid),
    .i_req_last   (req_last),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .i_fifo_full  (fifo_full),
    .o_fifo_write (fifo_write),
    .o_fifo_wdata (fifo_wdata),
    .o_busy       (busy),
    .o_grant_id   (grant_id),
    .o_timeout    (timeout)
  );

  typedef struct {
    int id;
    int data;
  } sb_t;

  typedef struct {
    int id;
    int len;
    int base;
    int exp_gid;
    int exp_busy;
    int exp_lat;
  } vec_t;

  logic [7:0] src_data [N][D];
  logic       src_last [N][D];
  int         src_wr [N];
  int         src_rd [N];
  logic [N-1:0] fire = '0;
  logic       rst_seen = 1'b0;

  sb_t  sb_q[$];
  int   sb_rd;
  int   wr_cyc[$];
  int   wr_cnt;
  int   busy_cnt;
  int   to_cnt;
  int   to_cyc;
  int   to_busy;
  int   cyc;
  int   n_run;
  int   n_fail;
  vec_t vecs [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Requester models: present queued bytes, advance on a sampled handshake,
  // drop everything queued when reset was seen.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < N; n++) begin
        if (rst_seen) src_rd[n] = src_wr[n];
        else if (fire[n]) src_rd[n]++;
        if (src_rd[n] < src_wr[n]) begin
          req_valid[n] = 1'b1;
          req_last[n]  = src_last[n][src_rd[n]];
          req_data[n*8 +: 8] = src_data[n][src_rd[n]];
        end else begin
          req_valid[n] = 1'b0;
          req_last[n]  = 1'b0;
          req_data[n*8 +: 8] = 8'h00;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n_run++;
    if ((fifo_write && (fifo_full || rst)) ||
        ($countones(req_ready) > 1) ||
        (rst && (req_ready != '0)) ||
        (fifo_write !== |(req_valid & req_ready))) begin
      n_fail++;
      $display("FAIL invariant: write=%0b full=%0b rst=%0b ready=%0h valid=%0h",
               fifo_write, fifo_full, rst, req_ready, req_valid);
    end
    if (fifo_write) begin
      n_run++;
      if (sb_rd >= sb_q.size()) begin
        n_fail++;
        $display("FAIL sb_extra: got id %0d data %02h, expected no write",
                 grant_id, fifo_wdata);
      end else begin
        if (int'(grant_id) != sb_q[sb_rd].id ||
            int'(fifo_wdata) != sb_q[sb_rd].data) begin
          n_fail++;
          $display("FAIL sb_data: got id %0d data %02h, expected id %0d data %02h",
                   grant_id, fifo_wdata, sb_q[sb_rd].id, sb_q[sb_rd].data);
        end
        sb_rd++;
      end
      wr_cyc.push_back(cyc);
      wr_cnt++;
    end
    if (timeout) begin
      to_cnt++;
      to_cyc  = cyc;
      to_busy = int'(busy);
    end
    if (busy) busy_cnt++;
    fire     = req_valid & req_ready;
    rst_seen = rst;
  endtask

  task automatic push_src(input int id, input int len, input int base,
                          input bit fin);
    for (int i = 0; i < len; i++) begin
      src_data[id][src_wr[id] + i] = 8'(base + i);
      src_last[id][src_wr[id] + i] = fin && (i == len - 1);
    end
    src_wr[id] += len;
  endtask

  task automatic sb_add(input int id, input int base, input int len);
    for (int i = 0; i < len; i++) sb_q.push_back('{id, (base + i) & 255});
  endtask

  task automatic push_pkt(input int id, input int len, input int base,
                          input bit fin);
    push_src(id, len, base, fin);
    sb_add(id, base, len);
  endtask

  function automatic bit srcs_empty();
    for (int n = 0; n < N; n++) if (src_rd[n] != src_wr[n]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int max, input string nm);
    for (int i = 0; i < max; i++) begin
      tick();
      if (!busy && srcs_empty() && sb_rd == sb_q.size()) return;
    end
    chk(nm, 0, 1);
  endtask

  task automatic wait_writes(input int target, input int max, input string nm);
    for (int i = 0; i < max; i++) begin
      tick();
      if (wr_cnt >= target) return;
    end
    chk(nm, wr_cnt, target);
  endtask

  int b0;
  int w0;
  int t0;
  int to0;

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    c_timeout = '0;
    n_run = 0; n_fail = 0; sb_rd = 0; wr_cnt = 0;
    busy_cnt = 0; to_cnt = 0; to_cyc = 0; to_busy = 0;

    vecs[0] = '{1, 2, 'h41, 1, 2, 1};
    vecs[1] = '{0, 3, 'h10, 0, 3, 1};
    vecs[2] = '{3, 1, 'h70, 3, 1, 1};
    vecs[3] = '{2, 4, 'hA0, 2, 4, 1};

    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_write", int'(fifo_write), 0);
    rst = 1'b0;
    tick();

    // Single-packet table: owner, busy length and first-write latency.
    for (int e = 0; e < 4; e++) begin
      b0 = busy_cnt;
      w0 = wr_cnt;
      push_pkt(vecs[e].id, vecs[e].len, vecs[e].base, 1'b1);
      t0 = cyc + 1;
      wait_idle(50, "tbl_idle");
      chk("tbl_grant", int'(grant_id), vecs[e].exp_gid);
      chk("tbl_busy", busy_cnt - b0, vecs[e].exp_busy);
      if (wr_cnt > w0) chk("tbl_latency", wr_cyc[w0] - t0, vecs[e].exp_lat);
      else chk("tbl_written", wr_cnt - w0, vecs[e].len);
    end

    // Round robin from a fresh pointer: order 0,2,0,2.
    @(posedge clk); #2; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    push_pkt(0, 2, 'h01, 1'b1);
    push_pkt(2, 2, 'h21, 1'b1);
    push_pkt(0, 2, 'h03, 1'b1);
    push_pkt(2, 2, 'h23, 1'b1);
    wait_idle(100, "rr_idle");
    chk("rr_last_grant", int'(grant_id), 2);

    // Backpressure: five full cycles mid-packet must not count as stall.
    c_timeout = TB'(3);
    to0 = to_cnt;
    w0 = wr_cnt;
    push_pkt(1, 4, 'h51, 1'b1);
    wait_writes(w0 + 1, 20, "bp_first");
    @(posedge clk); #2; fifo_full = 1'b1;
    repeat (5) tick();
    chk("bp_no_write", wr_cnt - w0, 1);
    chk("bp_busy", int'(busy), 1);
    @(posedge clk); #2; fifo_full = 1'b0;
    wait_idle(50, "bp_idle");
    chk("bp_no_timeout", to_cnt - to0, 0);

    // Timeout: owner 3 stalls after one byte; four stall cycles t+1..t+4,
    // pulse and IDLE follow the edge closing the fourth, then 0 before 1.
    c_timeout = TB'(4);
    to0 = to_cnt;
    w0 = wr_cnt;
    push_src(3, 1, 'h31, 1'b0);
    sb_add(3, 'h31, 1);
    wait_writes(w0 + 1, 20, "to_first");
    t0 = wr_cyc[w0];
    push_pkt(0, 2, 'h61, 1'b1);
    push_pkt(1, 2, 'h71, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (to_cnt > to0) break;
    end
    chk("to_pulse_cycle", to_cyc - t0, 5);
    chk("to_busy_at_pulse", to_busy, 0);
    wait_idle(50, "to_idle");
    chk("to_pulse_count", to_cnt - to0, 1);
    chk("to_last_grant", int'(grant_id), 1);

    // Reset during byte 2 of 4: only byte 1 leaves, then req0 wins.
    c_timeout = '0;
    w0 = wr_cnt;
    push_src(1, 4, 'h81, 1'b1);
    sb_add(1, 'h81, 1);
    wait_writes(w0 + 1, 20, "rs_first");
    @(posedge clk); #2; rst = 1'b1;
    tick();
    chk("rs_no_write", wr_cnt - w0, 1);
    tick();
    chk("rs_busy", int'(busy), 0);
    chk("rs_grant", int'(grant_id), 0);
    rst = 1'b0;
    repeat (2) tick();
    chk("rs_abandoned", wr_cnt - w0, 1);
    push_pkt(0, 2, 'hB1, 1'b1);
    push_pkt(1, 2, 'hC1, 1'b1);
    wait_idle(50, "rs_idle");
    chk("rs_last_grant", int'(grant_id), 1);

    // Timeout disabled: owner idles past counter range, grant is kept.
    to0 = to_cnt;
    w0 = wr_cnt;
    push_src(2, 1, 'hD1, 1'b0);
    sb_add(2, 'hD1, 1);
    wait_writes(w0 + 1, 20, "nt_first");
    repeat (1100) tick();
    chk("nt_busy", int'(busy), 1);
    chk("nt_grant", int'(grant_id), 2);
    chk("nt_no_timeout", to_cnt - to0, 0);
    chk("nt_saturated", int'(dut.stall_cnt), (1 << TB) - 1);
    push_pkt(2, 1, 'hD2, 1'b1);
    wait_idle(20, "nt_idle");
    chk("nt_final_grant", int'(grant_id), 2);

    chk("sb_drained", sb_rd, sb_q.size());
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
